// File: rtl/vertex_xform_pipe.sv
// Streaming vertex transform out = M*(v+T), 3-stage valid/ready pipeline with frame-safe config commit.
// Optional macro VXF_SATURATE_EN: clamp results to the DATA_W signed range instead of wrapping.
module vertex_xform_pipe #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 14,
  parameter int CNT_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [3:0]               cfg_addr,
  input  logic [15:0]              cfg_data,
  input  logic                     cfg_commit,
  output logic                     cfg_pending,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_y,
  input  logic signed [DATA_W-1:0] in_z,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_x,
  output logic signed [DATA_W-1:0] out_y,
  output logic signed [DATA_W-1:0] out_z,
  output logic                     out_last,
  output logic                     frame_done,
  output logic [CNT_W-1:0]         vtx_count
);
  localparam int PW = DATA_W + COEF_W + 1;
  localparam int SW = PW + 2;
  localparam logic signed [COEF_W-1:0] ONE  = COEF_W'(1) << FRAC_W;
  localparam logic signed [SW-1:0]     RND  = SW'(1) << (FRAC_W - 1);
  localparam logic signed [SW-1:0]     MAXV = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0]     MINV = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [COEF_W-1:0] sh_m [9];
  logic signed [COEF_W-1:0] act_m [9];
  logic signed [COEF_W-1:0] s1_m [9];
  logic signed [DATA_W-1:0] sh_t [3];
  logic signed [DATA_W-1:0] act_t [3];
  logic signed [DATA_W:0]   s1_t [3];
  logic signed [PW-1:0]     s2_p [9];
  logic signed [SW-1:0]     sum [3];
  logic signed [SW-1:0]     rnd [3];
  logic signed [DATA_W-1:0] res [3];
  logic frame_open, adv, acc, apply_ok, out_hs;
  logic s1_valid, s1_last, s2_valid, s2_last;

  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;
  assign acc      = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  // A commit may only land between frames: either idle with nothing starting, or on the closing beat.
  assign apply_ok = acc ? in_last : !frame_open;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 9; k++) begin
        sh_m[k]  <= (k % 4 == 0) ? ONE : '0;
        act_m[k] <= (k % 4 == 0) ? ONE : '0;
      end
      for (int unsigned k = 0; k < 3; k++) begin
        sh_t[k]  <= '0;
        act_t[k] <= '0;
      end
      cfg_pending <= 1'b0;
      frame_open  <= 1'b0;
    end else begin
      if (cfg_we) begin
        for (int unsigned k = 0; k < 9; k++)
          if (cfg_addr == 4'(k)) sh_m[k] <= cfg_data[COEF_W-1:0];
        for (int unsigned k = 0; k < 3; k++)
          if (cfg_addr == 4'(k + 9)) sh_t[k] <= cfg_data[DATA_W-1:0];
      end
      if (cfg_pending && apply_ok) begin
        act_m <= sh_m;
        act_t <= sh_t;
      end
      if (cfg_commit)
        cfg_pending <= 1'b1;
      else if (cfg_pending && apply_ok)
        cfg_pending <= 1'b0;
      if (acc) frame_open <= !in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_z      <= '0;
      frame_done <= 1'b0;
      vtx_count  <= '0;
    end else begin
      frame_done <= out_hs && out_last;
      if (frame_done)
        vtx_count <= out_hs ? CNT_W'(1) : '0;
      else if (out_hs)
        vtx_count <= vtx_count + 1'b1;
      if (adv) begin
        s1_valid  <= in_valid;
        s1_last   <= in_last;
        s2_valid  <= s1_valid;
        s2_last   <= s1_last;
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_last <= s2_last;
          out_x    <= res[0];
          out_y    <= res[1];
          out_z    <= res[2];
        end
      end
    end
  end

  // Datapath registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_t[0] <= (DATA_W+1)'(in_x) + (DATA_W+1)'(act_t[0]);
      s1_t[1] <= (DATA_W+1)'(in_y) + (DATA_W+1)'(act_t[1]);
      s1_t[2] <= (DATA_W+1)'(in_z) + (DATA_W+1)'(act_t[2]);
      s1_m    <= act_m;
      for (int unsigned k = 0; k < 9; k++)
        s2_p[k] <= PW'(s1_t[k % 3]) * PW'(s1_m[k]);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      sum[i] = SW'(s2_p[3*i]) + SW'(s2_p[3*i+1]) + SW'(s2_p[3*i+2]);
      rnd[i] = (sum[i] + RND) >>> FRAC_W;
`ifdef VXF_SATURATE_EN
      if (rnd[i] > MAXV)
        res[i] = {1'b0, {(DATA_W-1){1'b1}}};
      else if (rnd[i] < MINV)
        res[i] = {1'b1, {(DATA_W-1){1'b0}}};
      else
        res[i] = rnd[i][DATA_W-1:0];
`else
      res[i] = rnd[i][DATA_W-1:0];
`endif
    end
  end
endmodule

// File: tb/tb_vertex_xform_pipe.sv
// Scoreboard bench for vertex_xform_pipe: a cycle model predicts config timing and transformed vertices.
module tb_vertex_xform_pipe;
  localparam int DW = 16;
  localparam int NW = 12;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_we = 1'b0, cfg_commit = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic signed [DW-1:0] in_x = '0, in_y = '0, in_z = '0;
  logic cfg_pending, in_ready, out_valid, out_last, frame_done;
  logic signed [DW-1:0] out_x, out_y, out_z;
  logic [NW-1:0] vtx_count;

  vertex_xform_pipe #(.DATA_W(16), .COEF_W(16), .FRAC_W(14), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_last(out_last),
    .frame_done(frame_done), .vtx_count(vtx_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {int x; int y; int z; bit last;} exp_t;
  exp_t q[$];
  int m_sh[9], m_act[9], t_sh[3], t_act[3];
  bit m_pend, m_open, m_fd, model_on = 1'b0, hold, tgl = 1'b0;
  int m_cnt, fd_cnt = 0;
  logic signed [DW-1:0] hx, hy, hz;
  logic hl;

  function automatic int narrow(longint v);
`ifdef VXF_SATURATE_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
`else
    return int'(shortint'(v));
`endif
  endfunction

  function automatic int row(int i, int x, int y, int z);
    longint s;
    s = longint'(x + t_act[0]) * m_act[3*i] + longint'(y + t_act[1]) * m_act[3*i+1]
      + longint'(z + t_act[2]) * m_act[3*i+2];
    return narrow((s + 8192) >>> 14);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) begin
      m_sh[k]  = (k % 4 == 0) ? 16384 : 0;
      m_act[k] = m_sh[k];
    end
    for (int k = 0; k < 3; k++) begin
      t_sh[k]  = 0;
      t_act[k] = 0;
    end
    m_pend = 0; m_open = 0; m_fd = 0; m_cnt = 0; hold = 0;
    q.delete();
  endtask

  // Compare current DUT state, then advance the model to what the next rising edge produces.
  always @(negedge clk) begin
    exp_t e;
    bit acc, ok, apply, oh;
    if (model_on) begin
      check("cfg_pending", cfg_pending, m_pend);
      check("frame_done", frame_done, m_fd);
      check("vtx_count", vtx_count, m_cnt);
      check("in_ready", in_ready, !out_valid || out_ready);
      if (frame_done) fd_cnt++;
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_x", out_x, hx);
        check("hold_y", out_y, hy);
        check("hold_z", out_z, hz);
        check("hold_last", out_last, hl);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_beat", out_valid, 0);
        else begin
          e = q.pop_front();
          check("out_x", out_x, e.x);
          check("out_y", out_y, e.y);
          check("out_z", out_z, e.z);
          check("out_last", out_last, e.last);
        end
      end
    end
    if (!rst_n) begin
      model_reset();
      model_on = 1'b1;
    end else if (model_on) begin
      acc = in_valid && in_ready;
      oh  = out_valid && out_ready;
      ok  = acc ? in_last : !m_open;
      if (acc) begin
        e = '{row(0, in_x, in_y, in_z), row(1, in_x, in_y, in_z), row(2, in_x, in_y, in_z), in_last};
        q.push_back(e);
        m_open = !in_last;
      end
      if (m_fd) m_cnt = oh ? 1 : 0;
      else if (oh) m_cnt = (m_cnt + 1) % 4096;
      m_fd = oh && out_last;
      apply = m_pend && ok;
      if (apply) begin
        m_act = m_sh;
        t_act = t_sh;
      end
      if (cfg_commit) m_pend = 1;
      else if (apply) m_pend = 0;
      if (cfg_we) begin
        if (cfg_addr < 9) m_sh[cfg_addr] = int'($signed(cfg_data));
        else if (cfg_addr < 12) t_sh[cfg_addr-9] = int'($signed(cfg_data));
      end
      hold = out_valid && !out_ready;
      hx = out_x; hy = out_y; hz = out_z; hl = out_last;
    end
  end

  always @(posedge clk) begin
    #1;
    if (tgl) out_ready = !out_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = 16'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic send(input int x, input int y, input int z, input bit last);
    int n;
    n = 0;
    in_valid = 1'b1; in_last = last;
    in_x = DW'(x); in_y = DW'(y); in_z = DW'(z);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_applied();
    int n;
    n = 0;
    while (cfg_pending && n < 50) begin
      tick();
      n++;
    end
    check("commit_timeout", cfg_pending, 0);
  endtask

  task automatic drain();
    repeat (12) tick();
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fd0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_z", out_z, 0);
    check("rst_out_last", out_last, 0);
    check("rst_count", vtx_count, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // identity pass-through and pipeline latency
    send(100, -200, 300, 1'b0);
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    check("latency", n, 3);
    @(negedge clk);
    check("count_one", vtx_count, 1);
    tick();
    send(7, 8, 9, 1'b1);
    drain();

    // translation, idle commit
    wr(9, 10); wr(10, 20); wr(11, 30);
    commit();
    @(negedge clk);
    check("pend_set", cfg_pending, 1);
    @(negedge clk);
    check("pend_clear", cfg_pending, 0);
    tick();
    send(1, 2, 3, 1'b1);
    drain();

    // 90 and 45 degree rotations about z
    wr(9, 0); wr(10, 0); wr(11, 0);
    wr(0, 0); wr(1, -16384); wr(3, 16384); wr(4, 0);
    commit();
    wait_applied();
    send(1000, 0, 5, 1'b1);
    drain();
    wr(0, 11585); wr(1, -11585); wr(3, 11585); wr(4, 11585);
    commit();
    wait_applied();
    send(100, 0, 0, 1'b1);
    drain();

    // backpressure on the output side
    fd0 = fd_cnt;
    tgl = 1'b1;
    for (int i = 1; i <= 8; i++) send(i * 50, -i * 7, i, i == 8);
    repeat (20) tick();
    tgl = 1'b0;
    out_ready = 1'b1;
    drain();
    check("frame_done_once", fd_cnt - fd0, 1);

    // mid-frame commit waits for the frame's last input beat
    wr(9, 5); wr(10, 0); wr(11, 0);
    for (int i = 1; i <= 3; i++) send(i * 11, i, -i, 1'b0);
    commit();
    for (int i = 4; i <= 6; i++) begin
      if (i == 5) check("pend_mid_frame", cfg_pending, 1);
      send(i * 11, i, -i, i == 6);
    end
    check("pend_after_frame", cfg_pending, 0);
    send(40, 0, 0, 1'b1);
    drain();

    // overflow of the narrowed result
    wr(0, 32767); wr(1, 0); wr(3, 0); wr(4, 32767); wr(8, 32767); wr(9, 0);
    commit();
    wait_applied();
    send(30000, -30000, 0, 1'b1);
    drain();

    // reset while vertices are in flight
    in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_x = DW'(i * 3); in_y = DW'(i); in_z = DW'(-i);
      tick();
    end
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("rst_mid_valid", out_valid, 0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    send(9, 9, 9, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
